// File: rtl/btb_pkg.sv
// Shared types and field-extraction helpers for the branch target buffer.
// Table entries store the tag at its widest possible size so one struct serves every depth.
package btb_pkg;

    localparam int PC_W      = 32;
    localparam int TGT_W     = 16;
    localparam int IDX_MAX_W = 8;
    localparam int TAG_MAX_W = 12;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } btb_ctr_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [TGT_W-1:0]     target;
        btb_ctr_e             ctr;
    } btb_entry_t;

    function automatic logic [IDX_MAX_W-1:0] btb_index(input logic [PC_W-1:0] pc, input int idx_w);
        logic [IDX_MAX_W-1:0] mask;
        mask = (8'd1 << idx_w) - 8'd1;
        return pc[IDX_MAX_W+1:2] & mask;
    endfunction

    // Only the 64 KiB instruction space participates; pc[31:16] never reaches the tag.
    function automatic logic [TAG_MAX_W-1:0] btb_tag(input logic [PC_W-1:0] pc, input int idx_w);
        logic [TGT_W-1:0] shifted;
        shifted = pc[TGT_W-1:0] >> (idx_w + 2);
        return shifted[TAG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// Next-state logic for a 2-bit saturating direction counter.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  btb_ctr_e i_ctr,
    input  logic     i_inc,
    input  logic     i_dec,
    output btb_ctr_e o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc && (i_ctr != ST)) begin
            o_ctr = btb_ctr_e'(i_ctr + 2'd1);
        end else if (i_dec && (i_ctr != SNT)) begin
            o_ctr = btb_ctr_e'(i_ctr - 2'd1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational fetch lookup, EX resolve and training.
// Optional BTB_STATS_EN builds hit/mispredict counters; otherwise stat outputs are tied to zero.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int       ENTRIES  = 16,
    parameter btb_ctr_e CTR_INIT = WT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predictTaken,
    output logic [15:0] predictedTarget,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [15:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] correctTarget,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t r_table [ENTRIES];

    logic [IDX_MAX_W-1:0] w_fetchIdxFull;
    logic [IDX_MAX_W-1:0] w_exIdxFull;
    logic [IDX_W-1:0]     w_fetchIdx;
    logic [IDX_W-1:0]     w_exIdx;
    logic [TAG_MAX_W-1:0] w_fetchTag;
    logic [TAG_MAX_W-1:0] w_exTag;
    btb_entry_t           w_fetchEntry;
    btb_entry_t           w_exEntry;
    logic                 w_fetchHit;
    logic                 w_exHit;
    logic                 w_train;
    btb_ctr_e             w_nextCtr;
    logic                 w_unused;

    assign w_fetchIdxFull = btb_index(fetch_pc, IDX_W);
    assign w_exIdxFull    = btb_index(ex_pc, IDX_W);
    assign w_fetchIdx     = w_fetchIdxFull[IDX_W-1:0];
    assign w_exIdx        = w_exIdxFull[IDX_W-1:0];
    assign w_fetchTag     = btb_tag(fetch_pc, IDX_W);
    assign w_exTag        = btb_tag(ex_pc, IDX_W);
    assign w_unused       = ^{w_fetchIdxFull, w_exIdxFull};

    assign w_fetchEntry = r_table[w_fetchIdx];
    assign w_exEntry    = r_table[w_exIdx];
    assign w_fetchHit   = w_fetchEntry.valid && (w_fetchEntry.tag == w_fetchTag);
    assign w_exHit      = w_exEntry.valid && (w_exEntry.tag == w_exTag);

    assign predictTaken    = w_fetchHit && w_fetchEntry.ctr[1];
    assign predictedTarget = w_fetchHit ? w_fetchEntry.target : 16'd0;

    // Redirect is raised even under stall; the PC unit decides when to take it.
    assign mispredict    = ex_valid && ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target[15:0] != ex_pred_target)));
    assign correctTarget = ex_taken ? ex_target : (ex_pc + 32'd4);

    assign w_train = ex_valid && !stall;

    btb_sat_ctr u_satCtr (
        .i_ctr (w_exEntry.ctr),
        .i_inc (ex_taken),
        .i_dec (!ex_taken),
        .o_ctr (w_nextCtr)
    );

    // Miss + taken allocates over whatever aliases at that index; miss + not-taken leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (w_train) begin
            if (w_exHit) begin
                r_table[w_exIdx].ctr <= w_nextCtr;
                if (ex_taken) begin
                    r_table[w_exIdx].target <= ex_target[15:0];
                end
            end else if (ex_taken) begin
                r_table[w_exIdx] <= '{valid: 1'b1, tag: w_exTag, target: ex_target[15:0], ctr: CTR_INIT};
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_statHits;
    logic [31:0] r_statMispredicts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_statHits        <= 32'd0;
            r_statMispredicts <= 32'd0;
        end else if (!stall) begin
            if (predictTaken) begin
                r_statHits <= r_statHits + 32'd1;
            end
            if (mispredict) begin
                r_statMispredicts <= r_statMispredicts + 32'd1;
            end
        end
    end

    assign stat_hits        = r_statHits;
    assign stat_mispredicts = r_statMispredicts;
`else
    assign stat_hits        = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed scoreboard bench for btb_predictor (ENTRIES=16); honours BTB_STATS_EN when defined.
module tb_btb_predictor;

    typedef enum int {K_PT, K_PTGT, K_MISP, K_CTGT, K_HITS, K_MSTAT} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       tag;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic        predictTaken;
    logic [15:0] predictedTarget;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [15:0] ex_pred_target = 16'd0;
    logic        mispredict;
    logic [31:0] correctTarget;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;

    sb_item_t sbQueue[$];
    int       nVectors = 0;
    int       nMiscompares = 0;
    int       expHits = 0;
    int       expMisp = 0;
    logic     lastPt = 1'b0;
    logic     lastMisp = 1'b0;
    logic     lastStall = 1'b0;

    btb_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .rst              (rst_n),
        .fetch_pc         (fetch_pc),
        .predictTaken     (predictTaken),
        .predictedTarget  (predictedTarget),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .correctTarget    (correctTarget),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input kind_e k, input logic [31:0] e, input string t);
        sb_item_t it;
        it.kind = k;
        it.exp  = e;
        it.tag  = t;
        sbQueue.push_back(it);
    endtask

    // Drive one directed step and queue the outputs the DUT must show for it.
    task automatic applyStimulus(
        input string       t,
        input logic [31:0] fpc,
        input logic        st,
        input logic        v,
        input logic [31:0] pc,
        input logic        tk,
        input logic [31:0] tgt,
        input logic        pPt,
        input logic [15:0] pTgt,
        input logic        ePt,
        input logic [15:0] ePtgt,
        input logic        eMisp,
        input logic [31:0] eCtgt
    );
        fetch_pc       = fpc;
        stall          = st;
        ex_valid       = v;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = pPt;
        ex_pred_target = pTgt;
        lastPt    = ePt;
        lastMisp  = eMisp;
        lastStall = st;
        pushExp(K_PT,   {31'd0, ePt},   {t, ".predictTaken"});
        pushExp(K_PTGT, {16'd0, ePtgt}, {t, ".predictedTarget"});
        pushExp(K_MISP, {31'd0, eMisp}, {t, ".mispredict"});
        pushExp(K_CTGT, eCtgt,          {t, ".correctTarget"});
`ifdef BTB_STATS_EN
        pushExp(K_HITS,  expHits, {t, ".stat_hits"});
        pushExp(K_MSTAT, expMisp, {t, ".stat_mispredicts"});
`else
        pushExp(K_HITS,  32'd0, {t, ".stat_hits"});
        pushExp(K_MSTAT, 32'd0, {t, ".stat_mispredicts"});
`endif
    endtask

    task automatic checkOutput();
        sb_item_t    it;
        logic [31:0] obs;
        #1;
        while (sbQueue.size() > 0) begin
            it = sbQueue.pop_front();
            case (it.kind)
                K_PT:    obs = {31'd0, predictTaken};
                K_PTGT:  obs = {16'd0, predictedTarget};
                K_MISP:  obs = {31'd0, mispredict};
                K_CTGT:  obs = correctTarget;
                K_HITS:  obs = stat_hits;
                default: obs = stat_mispredicts;
            endcase
            nVectors++;
            assert (obs === it.exp) else begin
                nMiscompares++;
                $error("[TB] FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    // Advance one clock, crediting the expected counters for the step just checked.
    task automatic clockStep();
        @(posedge clk);
        if (rst_n && !lastStall) begin
            if (lastPt)   expHits++;
            if (lastMisp) expMisp++;
        end
        @(negedge clk);
    endtask

    initial begin
        // Held in reset: everything misses, no redirect.
        applyStimulus("rst", 32'h40, 0, 0, 32'h40, 0, 32'h0, 0, 16'h0, 0, 16'h0, 0, 32'h44);
        checkOutput();
        clockStep();
        rst_n = 1'b1;

        applyStimulus("alloc", 32'h40, 0, 1, 32'h40, 1, 32'h100, 0, 16'h0, 0, 16'h0, 1, 32'h100);
        checkOutput(); clockStep();
        applyStimulus("hitWT", 32'h40, 0, 0, 32'h40, 0, 32'h0, 0, 16'h0, 1, 16'h100, 0, 32'h44);
        checkOutput(); clockStep();
        applyStimulus("nt1", 32'h40, 0, 1, 32'h40, 0, 32'h0, 1, 16'h100, 1, 16'h100, 1, 32'h44);
        checkOutput(); clockStep();
        applyStimulus("nt2", 32'h40, 0, 1, 32'h40, 0, 32'h0, 0, 16'h0, 0, 16'h100, 0, 32'h44);
        checkOutput(); clockStep();
        applyStimulus("snt", 32'h40, 0, 0, 32'h40, 0, 32'h0, 0, 16'h0, 0, 16'h100, 0, 32'h44);
        checkOutput(); clockStep();
        applyStimulus("up1", 32'h40, 0, 1, 32'h40, 1, 32'h100, 0, 16'h0, 0, 16'h100, 1, 32'h100);
        checkOutput(); clockStep();
        applyStimulus("up2", 32'h40, 0, 1, 32'h40, 1, 32'h100, 0, 16'h0, 0, 16'h100, 1, 32'h100);
        checkOutput(); clockStep();
        applyStimulus("upWT", 32'h40, 0, 0, 32'h40, 0, 32'h0, 0, 16'h0, 1, 16'h100, 0, 32'h44);
        checkOutput(); clockStep();

        // 0x80 aliases 0x40 at index 0 with a different tag.
        applyStimulus("alias", 32'h80, 0, 1, 32'h80, 1, 32'h200, 0, 16'h0, 0, 16'h0, 1, 32'h200);
        checkOutput(); clockStep();
        applyStimulus("evict", 32'h40, 0, 0, 32'h80, 0, 32'h0, 0, 16'h0, 0, 16'h0, 0, 32'h84);
        checkOutput(); clockStep();
        applyStimulus("newHit", 32'h80, 0, 0, 32'h80, 0, 32'h0, 0, 16'h0, 1, 16'h200, 0, 32'h84);
        checkOutput(); clockStep();

        // Stalled resolve must not train but still redirects.
        applyStimulus("stall1", 32'h80, 1, 1, 32'h80, 0, 32'h0, 1, 16'h200, 1, 16'h200, 1, 32'h84);
        checkOutput(); clockStep();
        applyStimulus("stall2", 32'h80, 1, 1, 32'h80, 0, 32'h0, 1, 16'h200, 1, 16'h200, 1, 32'h84);
        checkOutput(); clockStep();
        applyStimulus("release", 32'h80, 0, 1, 32'h80, 0, 32'h0, 1, 16'h200, 1, 16'h200, 1, 32'h84);
        checkOutput(); clockStep();
        applyStimulus("oneStep", 32'h80, 0, 0, 32'h80, 0, 32'h0, 0, 16'h0, 0, 16'h200, 0, 32'h84);
        checkOutput(); clockStep();
        applyStimulus("reTake", 32'h80, 0, 1, 32'h80, 1, 32'h200, 0, 16'h0, 0, 16'h200, 1, 32'h200);
        checkOutput(); clockStep();
        applyStimulus("isWT", 32'h80, 0, 0, 32'h80, 0, 32'h0, 0, 16'h0, 1, 16'h200, 0, 32'h84);
        checkOutput(); clockStep();

        // Right direction, wrong target; then saturation at ST.
        applyStimulus("tgtMiss", 32'h80, 0, 1, 32'h80, 1, 32'h300, 1, 16'h200, 1, 16'h200, 1, 32'h300);
        checkOutput(); clockStep();
        applyStimulus("tgtOk", 32'h80, 0, 1, 32'h80, 1, 32'h300, 1, 16'h300, 1, 16'h300, 0, 32'h300);
        checkOutput(); clockStep();
        applyStimulus("satDn", 32'h80, 0, 1, 32'h80, 0, 32'h0, 1, 16'h300, 1, 16'h300, 1, 32'h84);
        checkOutput(); clockStep();
        applyStimulus("satChk", 32'h80, 0, 0, 32'h80, 0, 32'h0, 0, 16'h0, 1, 16'h300, 0, 32'h84);
        checkOutput(); clockStep();

        // Upper PC bits ignored on lookup; ex_pc+4 wraps at 32 bits.
        applyStimulus("wrap", 32'h0001_0080, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 16'h0, 1, 16'h300, 0, 32'h0);
        checkOutput(); clockStep();

        // Asynchronous reset in the middle of operation.
        rst_n = 1'b0;
        expHits = 0;
        expMisp = 0;
        applyStimulus("midRst", 32'h80, 0, 0, 32'h80, 0, 32'h0, 0, 16'h0, 0, 16'h0, 0, 32'h84);
        checkOutput(); clockStep();
        rst_n = 1'b1;
        applyStimulus("postRst", 32'h80, 0, 0, 32'h40, 0, 32'h0, 0, 16'h0, 0, 16'h0, 0, 32'h44);
        checkOutput(); clockStep();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
